// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver (and a future
// transmitter): parity mode constants, receiver FSM state type, parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DELIVER,
    ST_BREAK
  } rx_state_t;

  // Expected parity bit for up to 9 data bits (zero-extend narrower words).
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: byte-stream output of the UART receiver.
//   data_out    received word, stable while data_valid=1
//   data_valid  holding register full
//   data_ready  consumer accepts (transfer on valid & ready)
//   frame_err   stop bit sampled 0 (qualified by data_valid)
//   parity_err  parity mismatch (qualified by data_valid)
//   overrun_err 1-clk pulse: frame dropped because holding register was full
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output data_out, data_valid, frame_err, parity_err, overrun_err,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, frame_err, parity_err, overrun_err,
    output data_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk sample tick every
// CLK_DIV clocks (CLK_DIV=1 gives a tick every clock).
//   clk   clock
//   rst   asynchronous active-low reset
//   tick  1 for one clk when the counter wraps
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, LSB-first frames of start, DATA_BITS
// data, optional parity and STOP_BITS stop bits, with a valid/ready holding
// register and framing/parity/overrun flags.
//   clk     clock (rising edge)
//   rst     asynchronous active-low reset
//   bit_in  raw serial line, idle high, asynchronous to clk
//   rx      uart_rx_os_if.master: data_out/data_valid/data_ready and error flags
//   busy    1 whenever the FSM is not idle
// Build option: define UART_RX_MAJORITY_VOTE_EN to take each bit as the
// majority of three consecutive sample ticks instead of a single sample.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  uart_rx_os_if.master  rx,
  output logic          busy
);
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  // The clock that detects the falling edge stands in for the first tick of the
  // start bit: the synchroniser already delays the line, and this keeps the
  // stop-bit decision early enough to catch a back-to-back start edge.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int unsigned START_TICKS = OVERSAMPLE / 2;
`else
  localparam int unsigned START_TICKS = OVERSAMPLE / 2 - 1;
`endif

  rx_state_t            state, state_nxt;
  logic                 sync1, sync2, line_prev;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_err_int, parity_err_int;
  logic                 sample_now, sample_bit;
  logic                 accept, load;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Samples from the two previous ticks; with the current one they form the
  // vote window, so every decision lands one tick after the nominal mid point.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hist <= '1;
    else if (tick) hist <= {hist[0], sync2};
  end

  assign sample_bit = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
  assign sample_bit = sync2;
`endif

  assign busy           = (state != ST_IDLE);
  assign accept         = !rx.data_valid || rx.data_ready;
  assign load           = (state == ST_DELIVER) && accept;
  assign rx.overrun_err = (state == ST_DELIVER) && !accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sample_now = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (line_prev && !sync2) state_nxt = ST_START;
      end
      ST_START: begin
        if (tick && os_cnt == OS_W'(START_TICKS - 1)) begin
          sample_now = 1'b1;
          state_nxt  = sample_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && os_cnt == OS_W'(OVERSAMPLE - 1)) begin
          sample_now = 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1))
            state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick && os_cnt == OS_W'(OVERSAMPLE - 1)) begin
          sample_now = 1'b1;
          state_nxt  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && os_cnt == OS_W'(OVERSAMPLE - 1)) begin
          sample_now = 1'b1;
          if (bit_cnt == 4'(STOP_BITS - 1)) state_nxt = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        state_nxt = sync2 ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (sync2) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Synchroniser, tick/bit counters and frame assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      line_prev      <= 1'b1;
      os_cnt         <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      frame_err_int  <= 1'b0;
      parity_err_int <= 1'b0;
    end else begin
      sync1     <= bit_in;
      sync2     <= sync1;
      line_prev <= sync2;

      if (state == ST_IDLE) begin
        os_cnt         <= '0;
        bit_cnt        <= '0;
        frame_err_int  <= 1'b0;
        parity_err_int <= 1'b0;
      end else if (tick && state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
        os_cnt <= sample_now ? '0 : os_cnt + OS_W'(1);
      end

      if (sample_now) begin
        unique case (state)
          ST_DATA: begin
            shreg   <= {sample_bit, shreg[DATA_BITS-1:1]};
            bit_cnt <= (state_nxt == ST_DATA) ? bit_cnt + 4'd1 : 4'd0;
          end
          ST_PARITY: begin
            parity_err_int <= (parity_bit(9'(shreg), PARITY_MODE) != sample_bit);
          end
          ST_STOP: begin
            if (!sample_bit) frame_err_int <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

  // Holding register: a reload in the same clk as a transfer keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.data_out   <= '0;
      rx.data_valid <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
    end else if (load) begin
      rx.data_out   <= shreg;
      rx.data_valid <= 1'b1;
      rx.frame_err  <= frame_err_int;
      rx.parity_err <= parity_err_int;
    end else if (rx.data_valid && rx.data_ready) begin
      rx.data_valid <= 1'b0;
    end
  end
endmodule
